// File: rtl/mem_arbiter.sv
// Shares one 6502-style memory bus between the CPU core and a DMA requester.
// DMA wins contention for at most BURST_MAX cycles before the CPU is given one slot.
module mem_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_RW,
    input  logic [15:0] cpu_AD,
    input  logic [7:0]  cpu_D_out,
    output logic        cpu_gnt,
    output logic [7:0]  cpu_D_in,
    output logic        cpu_valid,
    input  logic        dma_req,
    input  logic        dma_RW,
    input  logic [15:0] dma_AD,
    input  logic [7:0]  dma_D_out,
    output logic        dma_gnt,
    output logic [7:0]  dma_D_in,
    output logic        dma_valid,
    output logic        mem_RW,
    output logic [15:0] mem_AD,
    output logic [7:0]  mem_D_out,
    input  logic [7:0]  mem_D_in
);

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DMA  = 2'd2
    } owner_t;

    localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

    logic [3:0] burst_cnt;
    owner_t     rd_owner;
    logic       dma_wins;

    always_comb begin
        dma_wins = dma_req && (!cpu_req || (burst_cnt < BURST_LIMIT));
        dma_gnt  = rst_n && dma_wins;
        cpu_gnt  = rst_n && cpu_req && !dma_wins;
    end

    // An ungranted cycle issues a harmless read of address 0 whose data is ignored.
    always_comb begin
        mem_RW    = 1'b1;
        mem_AD    = 16'h0000;
        mem_D_out = 8'h00;
        if (dma_gnt) begin
            mem_RW    = dma_RW;
            mem_AD    = dma_AD;
            mem_D_out = dma_D_out;
        end else if (cpu_gnt) begin
            mem_RW    = cpu_RW;
            mem_AD    = cpu_AD;
            mem_D_out = cpu_D_out;
        end
    end

    // Gating with rst_n drops a read that was in flight when reset arrived.
    always_comb begin
        cpu_valid = rst_n && (rd_owner == OWNER_CPU);
        dma_valid = rst_n && (rd_owner == OWNER_DMA);
        cpu_D_in  = cpu_valid ? mem_D_in : 8'h00;
        dma_D_in  = dma_valid ? mem_D_in : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_cnt <= 4'd0;
            rd_owner  <= OWNER_NONE;
        end else begin
            if (dma_gnt)
                burst_cnt <= (burst_cnt >= BURST_LIMIT) ? BURST_LIMIT : burst_cnt + 4'd1;
            else
                burst_cnt <= 4'd0;

            if (dma_gnt && dma_RW)
                rd_owner <= OWNER_DMA;
            else if (cpu_gnt && cpu_RW)
                rd_owner <= OWNER_CPU;
            else
                rd_owner <= OWNER_NONE;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter, checked against a behavioural
// model that tracks the current DMA run length and the reads awaiting return.
module tb_mem_arbiter;

    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_RW, dma_req, dma_RW;
    logic [15:0] cpu_AD, dma_AD;
    logic [7:0]  cpu_D_out, dma_D_out, mem_D_in;
    logic        cpu_gnt, cpu_valid, dma_gnt, dma_valid, mem_RW;
    logic [7:0]  cpu_D_in, dma_D_in, mem_D_out;
    logic [15:0] mem_AD;

    int    total = 0;
    int    bad   = 0;
    int    dma_run = 0;
    int    return_q[$];
    string g_hist;

    mem_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_RW(cpu_RW), .cpu_AD(cpu_AD), .cpu_D_out(cpu_D_out),
        .cpu_gnt(cpu_gnt), .cpu_D_in(cpu_D_in), .cpu_valid(cpu_valid),
        .dma_req(dma_req), .dma_RW(dma_RW), .dma_AD(dma_AD), .dma_D_out(dma_D_out),
        .dma_gnt(dma_gnt), .dma_D_in(dma_D_in), .dma_valid(dma_valid),
        .mem_RW(mem_RW), .mem_AD(mem_AD), .mem_D_out(mem_D_out), .mem_D_in(mem_D_in)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkSequence(input string tag, input string observed, input string expected);
        total++;
        assert (observed == expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%s expected=%s", tag, observed, expected);
        end
    endtask

    // One bus cycle: drive inputs, predict grant and read return, compare, advance.
    task automatic applyStimulus(input logic rst, input logic c_req, input logic c_rw,
                                 input logic [15:0] c_ad, input logic [7:0] c_do,
                                 input logic d_req, input logic d_rw,
                                 input logic [15:0] d_ad, input logic [7:0] d_do,
                                 input logic [7:0] m_di);
        int grant;
        int ret;
        logic        e_rw;
        logic [15:0] e_ad;
        logic [7:0]  e_do;
        rst_n = rst; cpu_req = c_req; cpu_RW = c_rw; cpu_AD = c_ad; cpu_D_out = c_do;
        dma_req = d_req; dma_RW = d_rw; dma_AD = d_ad; dma_D_out = d_do; mem_D_in = m_di;
        #2;
        ret = return_q.pop_front();
        if (!rst) ret = 0;
        grant = 0;
        if (rst) begin
            if (d_req && (!c_req || dma_run < BURST_MAX)) grant = 2;
            else if (c_req) grant = 1;
        end
        e_rw = 1'b1; e_ad = 16'h0000; e_do = 8'h00;
        if (grant == 2) begin e_rw = d_rw; e_ad = d_ad; e_do = d_do; end
        if (grant == 1) begin e_rw = c_rw; e_ad = c_ad; e_do = c_do; end
        g_hist = {g_hist, (grant == 2) ? "D" : (grant == 1) ? "C" : "-"};

        checkOutput("cpu_gnt",   16'(cpu_gnt),   16'(grant == 1));
        checkOutput("dma_gnt",   16'(dma_gnt),   16'(grant == 2));
        checkOutput("mem_RW",    16'(mem_RW),    16'(e_rw));
        checkOutput("mem_AD",    mem_AD,         e_ad);
        checkOutput("mem_D_out", 16'(mem_D_out), 16'(e_do));
        checkOutput("cpu_valid", 16'(cpu_valid), 16'(ret == 1));
        checkOutput("dma_valid", 16'(dma_valid), 16'(ret == 2));
        checkOutput("cpu_D_in",  16'(cpu_D_in),  (ret == 1) ? 16'(m_di) : 16'h0000);
        checkOutput("dma_D_in",  16'(dma_D_in),  (ret == 2) ? 16'(m_di) : 16'h0000);

        if (!rst) dma_run = 0;
        else dma_run = (grant == 2) ? dma_run + 1 : 0;
        if (rst && grant == 1 && c_rw) return_q.push_back(1);
        else if (rst && grant == 2 && d_rw) return_q.push_back(2);
        else return_q.push_back(0);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic [7:0] m_di);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 1'b0, 1'b1, 16'h0, 8'h0, m_di);
    endtask

    initial begin
        return_q.push_back(0);
        @(posedge clk);
        #1;

        $display("[TB] reset with both requesters active");
        g_hist = "";
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1111, 8'h00, 1'b1, 1'b1, 16'h2222, 8'h00, 8'h5A);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1111, 8'h00, 1'b1, 1'b1, 16'h2222, 8'h00, 8'h5A);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111, 8'h00, 1'b1, 1'b1, 16'h2222, 8'h00, 8'h5A);
        checkSequence("reset_release", g_hist, "--D");

        $display("[TB] CPU-only read");
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h00);
        idleCycle(8'hA9);

        $display("[TB] full contention");
        g_hist = "";
        for (int i = 0; i < 15; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 16'($urandom), 8'($urandom),
                          1'b1, 1'b1, 16'($urandom), 8'($urandom), 8'($urandom));
        checkSequence("contention", g_hist, "DDDDCDDDDCDDDDC");

        $display("[TB] DMA write");
        idleCycle(8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0200, 8'h55, 8'h77);
        idleCycle(8'h66);

        $display("[TB] owner switch on back-to-back reads");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0300, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0400, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h11);
        idleCycle(8'h22);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++)
            applyStimulus(logic'($urandom_range(0, 19) != 0),
                          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                          16'($urandom), 8'($urandom),
                          logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                          16'($urandom), 8'($urandom), 8'($urandom));

        $display("[TB] reset in the middle of a DMA burst");
        idleCycle(8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0500, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0501, 8'h00, 8'h33);
        g_hist = "";
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0600, 8'h00, 1'b1, 1'b1, 16'h0502, 8'h00, 8'h44);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h0600, 8'h00, 1'b1, 1'b1, 16'h0503, 8'h00, 8'($urandom));
        checkSequence("reset_mid_burst", g_hist, "-DDDDC");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 6502-style memory bus (RW, 16-bit address, 8-bit data in/out) between the CPU core and a DMA requester. It sits between `core` (and the DMA engine) and the memory, and decides each cycle which requester drives the bus. DMA has priority, with a bounded burst so the CPU cannot starve. Read data from the memory's one-cycle read latency is routed back to whichever requester issued the read.

## Interface
Parameters:
- `BURST_MAX`, default 4: maximum consecutive DMA grants while `cpu_req` is high before one CPU grant is forced. Legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset; **synchronous, active-low**.
- `cpu_req`  in  1  CPU requests the bus this cycle.
- `cpu_RW`  in  1  CPU direction: 1 = read, 0 = write.
- `cpu_AD`  in  16  CPU address.
- `cpu_D_out`  in  8  CPU write data.
- `cpu_gnt`  out  1  CPU owns the bus this cycle. This is the core's RDY: the core holds its state when it is low.
- `cpu_D_in`  out  8  read data to the CPU.
- `cpu_valid`  out  1  `cpu_D_in` holds data for the CPU read granted in the previous cycle.
- `dma_req`, `dma_RW`, `dma_AD[15:0]`, `dma_D_out[7:0]`  in: DMA equivalents of the CPU inputs.
- `dma_gnt`, `dma_D_in[7:0]`, `dma_valid`  out: DMA equivalents of the CPU outputs.
- `mem_RW`  out  1  memory direction.
- `mem_AD`  out  16  memory address.
- `mem_D_out`  out  8  memory write data.
- `mem_D_in`  in  8  memory read data, valid one cycle after the read address.

## Operation
Registered state:
- `burst_cnt[3:0]`: consecutive DMA grants.
- `rd_owner[1:0]`: NONE / CPU / DMA. Records who issued a read in the previous cycle.

Grant logic (combinational from requests and `burst_cnt`):
- `rst_n` = 0: no grant.
- Only `dma_req`: DMA.
- Only `cpu_req`: CPU.
- Both requesting: DMA if `burst_cnt < BURST_MAX`, otherwise CPU.
- `cpu_gnt` and `dma_gnt` are never high together.

Bus mux:
- Granted requester's RW, AD and D_out drive `mem_*`.
- No grant: `mem_RW`=1, `mem_AD`=16'h0000, `mem_D_out`=8'h00. The idle read result is discarded.

`burst_cnt` update:
- DMA granted: `burst_cnt`+1, saturating at `BURST_MAX`.
- CPU granted or no grant: cleared to 0.
- If `cpu_req` is low, DMA bursts are unlimited and the counter stays saturated.

`rd_owner` update:
- Set to the granted requester if that grant is a read (RW=1).
- Otherwise NONE, including writes and idle cycles.

Read return:
- `cpu_valid` = (`rd_owner`==CPU); `dma_valid` = (`rd_owner`==DMA).
- The valid requester's `*_D_in` = `mem_D_in`.
- The non-valid requester's `*_D_in` = 8'h00.
- At most one valid per cycle.

Writes complete in the granted cycle and produce no valid.

## Timing
Grant and bus decision:
- Grants and `mem_*` outputs are combinational, same cycle as the request. The memory samples the address/write at the end of the granted cycle.

Latency:
- Read latency is 1 cycle: read granted in cycle N gives `*_valid`=1 in cycle N+1 only.
- Back-to-back reads from different owners return in order with no gap.
- A grant in cycle N+1 is independent of the read returning in N+1.

Reset:
- `rst_n` sampled low at an edge: `burst_cnt`=0, `rd_owner`=NONE.
- From then on, while `rst_n` is low: `cpu_gnt`=`dma_gnt`=0, `cpu_valid`=`dma_valid`=0, `cpu_D_in`=`dma_D_in`=8'h00, `mem_RW`=1, `mem_AD`=16'h0000, `mem_D_out`=8'h00.
- A read granted in the cycle before reset asserts is dropped (no valid after reset).
- First grant is possible in the first cycle with `rst_n`=1.

Boundary conditions:
- Both requesting at `burst_cnt`==`BURST_MAX`: CPU gets exactly one cycle, the counter clears, and DMA then regains priority.
- `BURST_MAX`=1: strict alternation under full contention.
- A requester dropping `*_req` mid-burst loses its grant the same cycle.

## Test plan
1. **Reset:** `rst_n`=0 for 2 cycles with both requests high, then release.
   - During reset: no grant, `mem_RW`=1, `mem_AD`=0000, both valids 0.
   - First cycle after release: `dma_gnt`=1.
2. **CPU-only read:** `cpu_AD`=16'h1234, read; memory returns 8'hA9.
   - Cycle N: `cpu_gnt`=1, `mem_AD`=1234.
   - Cycle N+1: `cpu_valid`=1, `cpu_D_in`=A9, `dma_valid`=0.
3. **Full contention, `BURST_MAX`=4:** both requests held high for 15 cycles.
   - Grant sequence: D D D D C D D D D C D D D D C.
4. **DMA write:** `dma_RW`=0, `dma_AD`=0200, `dma_D_out`=55.
   - Cycle N: `mem_RW`=0, `mem_AD`=0200, `mem_D_out`=55.
   - Cycle N+1: no valid asserted.
5. **Owner switch on reads:** DMA read of 0300 in cycle N (memory returns 11), CPU read of 0400 in N+1 (memory returns 22).
   - N+1: `dma_valid`=1, `dma_D_in`=11.
   - N+2: `cpu_valid`=1, `cpu_D_in`=22.
   - Never both valids high.
6. **Reset mid-burst:** assert `rst_n`=0 after 2 DMA read grants, release after 1 cycle, both requests high.
   - No stale `dma_valid` after reset.
   - Next 4 grants are DMA, then CPU (counter was cleared).
